// File: rtl/mem_stage_dmem.sv
// MEM stage: byte-addressable data memory with a LATENCY-cycle wait per access and a Stall to the hazard unit.
// Latency: Stall is high for LATENCY+1 cycles and the op completes in DONE. Optional MISALIGN_TRAP_EN adds the Misalign output.
module mem_stage_dmem #(
    parameter int DEPTH   = 256,
    parameter int AW      = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] InAluRes,
    input  logic [31:0] InWriteData,
    input  logic        InMemRead,
    input  logic        InMemWrite,
    input  logic [1:0]  InSize,
    input  logic        InSignExt,
    input  logic        InMuxD,
    output logic [31:0] DataOut,
    output logic [31:0] AluResOut,
    output logic        MuxD_Out,
    output logic        Valid_Out,
`ifdef MISALIGN_TRAP_EN
    output logic        Misalign,
`endif
    output logic        Stall
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_addr, r_wdata, r_dout;
    logic [1:0]    r_size;
    logic          r_sext, r_muxd, r_is_store, r_valid, r_mis;

    logic [31:0]   r_mem [DEPTH];

    logic          w_req, w_exec, w_misalign;
    logic [1:0]    w_lane;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_word, w_load, w_wdat;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [3:0]    w_be;

    assign w_req  = InMemRead | InMemWrite;
    assign w_exec = (r_state == S_WAIT) && (r_cnt == '0);
    assign w_idx  = r_addr[AW+1:2];
    assign w_word = r_mem[w_idx];

`ifdef MISALIGN_TRAP_EN
    assign w_lane     = r_addr[1:0];
    assign w_misalign = ((r_size == 2'b01) && r_addr[0]) || (r_size[1] && (r_addr[1:0] != 2'b00));
`else
    // Without the trap, misaligned halves/words are silently aligned down.
    assign w_lane     = (r_size == 2'b00) ? r_addr[1:0] :
                        (r_size == 2'b01) ? {r_addr[1], 1'b0} : 2'b00;
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req) w_next = S_WAIT;
            S_WAIT:  if (r_cnt == '0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        Stall     = rst_n && (((r_state == S_IDLE) && w_req) || (r_state == S_WAIT));
        AluResOut = (r_state == S_IDLE) ? InAluRes : r_addr;
        MuxD_Out  = (r_state == S_IDLE) ? InMuxD   : r_muxd;
    end

    always_comb begin
        w_byte = 8'(w_word >> {w_lane, 3'b000});
        w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];
        case (r_size)
            2'b00:   w_load = {{24{r_sext & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_sext & w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    always_comb begin
        case (r_size)
            2'b00: begin
                w_be   = 4'b0001 << w_lane;
                w_wdat = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be   = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdat = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be   = 4'b1111;
                w_wdat = r_wdata;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= '0;
            r_sext     <= 1'b0;
            r_muxd     <= 1'b0;
            r_is_store <= 1'b0;
            r_dout     <= '0;
            r_valid    <= 1'b0;
            r_mis      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_req) begin
                    r_addr     <= InAluRes;
                    r_wdata    <= InWriteData;
                    r_size     <= InSize;
                    r_sext     <= InSignExt;
                    r_muxd     <= InMuxD;
                    r_is_store <= InMemWrite;
                    r_cnt      <= CW'(LATENCY - 1);
                end
                S_WAIT: if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end else begin
                    r_dout  <= (r_is_store || w_misalign) ? 32'h0 : w_load;
                    r_valid <= 1'b1;
                    r_mis   <= w_misalign;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_mis   <= 1'b0;
                end
            endcase
        end
    end

    // Array is not reset; the rst_n gate drops a store whose commit edge coincides with reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_exec && r_is_store && !w_misalign) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdat[8*b +: 8];
            end
        end
    end

    assign DataOut   = r_dout;
    assign Valid_Out = r_valid;
`ifdef MISALIGN_TRAP_EN
    assign Misalign  = r_mis;
`else
    logic w_unused;
    assign w_unused = r_mis;
`endif

endmodule
